// File: rtl/data_bus_resp.sv
// data_bus_resp: data-memory port responder with byte-lane RAM, compare timer
// and latched rising-edge external interrupts driving the CPU int vector.
module data_bus_resp #(
   parameter int          MEM_AW    = 10,
   parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ram_ce_i,
   input  logic        ram_we_i,
   input  logic [3:0]  ram_sel_i,
   input  logic [31:0] ram_addr_i,
   input  logic [31:0] ram_data_i,
   output logic [31:0] ram_data_o,
   input  logic [3:0]  ext_irq_i,
   output logic [5:0]  int_o
);
   logic [31:0] mem [2**MEM_AW];
   logic [31:0] count, compare, scratch, mmio_rd;
   logic [4:0]  pending, enable, irq, set, clr;
   logic [3:0]  sync1, sync2, prev;
   logic [MEM_AW-1:0] idx;
   logic [9:0]  off;
   logic        mmio, wr, reg_wr, unused;

   assign mmio   = ram_addr_i[31:12] == MMIO_BASE[31:12];
   assign idx    = ram_addr_i[MEM_AW+1:2];
   assign off    = ram_addr_i[11:2];
   assign wr     = ram_ce_i & ram_we_i;
   assign reg_wr = wr & mmio & (ram_sel_i == 4'hF);
   assign unused = ^ram_addr_i[1:0];
   // a new edge or timer match in the same cycle as a W1C keeps the bit set
   assign set    = {count == compare && compare != 32'd0, sync2 & ~prev};
   assign clr    = reg_wr && off == 10'd2 ? ram_data_i[4:0] : 5'd0;

   always_comb
      mmio_rd = off == 10'd0 ? count :
                off == 10'd1 ? compare :
                off == 10'd2 ? {27'd0, pending} :
                off == 10'd3 ? {27'd0, enable} :
                off == 10'd4 ? scratch : 32'd0;

   assign ram_data_o = rst && ram_ce_i && !ram_we_i ? (mmio ? mmio_rd : mem[idx]) : 32'd0;
   assign int_o      = {1'b0, irq};

   always_ff @(posedge clk)
      if (rst && wr && !mmio)
         for (int i = 0; i < 4; i++)
            if (ram_sel_i[i]) mem[idx][8*i +: 8] <= ram_data_i[8*i +: 8];

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         count   <= 32'd0;
         compare <= 32'd0;
         scratch <= 32'd0;
         pending <= 5'd0;
         enable  <= 5'd0;
         irq     <= 5'd0;
         sync1   <= 4'd0;
         sync2   <= 4'd0;
         prev    <= 4'd0;
      end else begin
         count   <= reg_wr && off == 10'd0 ? ram_data_i : count + 32'd1;
         compare <= reg_wr && off == 10'd1 ? ram_data_i : compare;
         enable  <= reg_wr && off == 10'd3 ? ram_data_i[4:0] : enable;
         scratch <= reg_wr && off == 10'd4 ? ram_data_i : scratch;
         pending <= (pending & ~clr) | set;
         irq     <= pending & enable;
         sync1   <= ext_irq_i;
         sync2   <= sync1;
         prev    <= sync2;
      end
endmodule

// File: tb/tb_data_bus_resp.sv
// tb_data_bus_resp: directed scenarios plus randomized traffic against a
// cycle-level reference model of the data bus responder.
module tb_data_bus_resp;
   localparam int          MEM_AW = 10;
   localparam logic [31:0] MB     = 32'h1000_0000;

   logic        clk = 0, rst = 0, ce = 0, we = 0;
   logic [3:0]  sel = 0, ext = 0;
   logic [31:0] addr = 0, wdata = 0, rdata, last_rd;
   logic [5:0]  int_o;
   int errors = 0, checks = 0;

   data_bus_resp #(.MEM_AW(MEM_AW), .MMIO_BASE(MB)) dut (
      .clk(clk), .rst(rst), .ram_ce_i(ce), .ram_we_i(we), .ram_sel_i(sel),
      .ram_addr_i(addr), .ram_data_i(wdata), .ram_data_o(rdata),
      .ext_irq_i(ext), .int_o(int_o));

   always #5 clk = ~clk;

   // reference state
   logic [31:0] m_mem [int];
   logic [31:0] m_count, m_cmp, m_scr;
   logic [4:0]  m_pend, m_en, m_int;
   logic [3:0]  h1, h2, h3;  // ext samples taken 1, 2 and 3 edges ago

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_count = 0; m_cmp = 0; m_scr = 0; m_pend = 0; m_en = 0; m_int = 0;
      h1 = 0; h2 = 0; h3 = 0;
   endtask

   function automatic logic [31:0] exp_rd(logic [31:0] a);
      int i;
      i = int'(a[MEM_AW+1:2]);
      if (a[31:12] != MB[31:12]) return m_mem.exists(i) ? m_mem[i] : 32'hx;
      case (a[11:2])
         10'd0: return m_count;
         10'd1: return m_cmp;
         10'd2: return {27'd0, m_pend};
         10'd3: return {27'd0, m_en};
         10'd4: return m_scr;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_edge();
      logic mm, rw;
      logic [9:0] off;
      logic [4:0] set, clr;
      logic [31:0] w;
      int i;
      mm  = addr[31:12] == MB[31:12];
      off = addr[11:2];
      rw  = ce && we && mm && sel == 4'hF;
      set = {m_count == m_cmp && m_cmp != 0, h2 & ~h3};
      clr = (rw && off == 2) ? wdata[4:0] : 5'd0;
      m_int  = m_pend & m_en;
      m_pend = (m_pend & ~clr) | set;
      m_count = (rw && off == 0) ? wdata : m_count + 1;
      if (rw && off == 1) m_cmp = wdata;
      if (rw && off == 3) m_en = wdata[4:0];
      if (rw && off == 4) m_scr = wdata;
      if (ce && we && !mm) begin
         i = int'(addr[MEM_AW+1:2]);
         w = m_mem.exists(i) ? m_mem[i] : 32'd0;
         for (int b = 0; b < 4; b++)
            if (sel[b]) w[8*b +: 8] = wdata[8*b +: 8];
         m_mem[i] = w;
      end
      h3 = h2; h2 = h1; h1 = ext;
   endtask

   // one bus cycle, starting and ending at a negedge
   task automatic step(bit c, bit w, logic [3:0] s, logic [31:0] a, logic [31:0] d, logic [3:0] e);
      ce = c; we = w; sel = s; addr = a; wdata = d; ext = e;
      #1;
      last_rd = rdata;
      if (c && !w) chk("read", rdata, exp_rd(a));
      else chk("rdata_idle", rdata, 32'd0);
      @(posedge clk);
      model_edge();
      #1;
      chk("int_o", {26'd0, int_o}, {27'd0, m_int});
      @(negedge clk);
   endtask

   task automatic wr_(logic [31:0] a, logic [31:0] d, logic [3:0] s = 4'hF, logic [3:0] e = 4'h0);
      step(1, 1, s, a, d, e);
   endtask

   task automatic rd_(logic [31:0] a, logic [3:0] e = 4'h0);
      step(1, 0, 4'hF, a, 32'd0, e);
   endtask

   task automatic idle(logic [3:0] e = 4'h0);
      step(0, 0, 4'h0, 32'd0, 32'd0, e);
   endtask

   logic [31:0] ra, rd;
   logic [3:0]  rs;

   initial begin
      m_reset();
      #12;
      chk("reset_int_o", {26'd0, int_o}, 32'd0);
      ce = 1; we = 0; addr = MB; #1;
      chk("reset_rdata", rdata, 32'd0);
      ce = 0;
      @(negedge clk);
      rst = 1;
      rd_(MB);
      chk("count_after_reset", last_rd, 32'd0);
      for (int i = 0; i < 16; i++) wr_(32'(i) << 2, $urandom);

      // byte-lane merge
      wr_(32'h40, 32'hDEADBEEF);
      wr_(32'h40, 32'h0000AA00, 4'b0010);
      rd_(32'h40);
      chk("lane_merge", last_rd, 32'hDEADAAEF);

      // idle/write return zero; aliasing
      idle();
      wr_(32'h80, 32'hCAFEF00D);
      rd_(32'h80 + (32'd4 << MEM_AW));
      chk("alias", last_rd, 32'hCAFEF00D);

      // timer match across the wrap
      wr_(MB + 32'h0, 32'hFFFF_FFFE);
      wr_(MB + 32'h4, 32'h0000_0002);
      wr_(MB + 32'hC, 32'h0000_0010);
      idle(); idle(); idle();
      chk("timer_int_not_yet", {26'd0, int_o}, 32'd0);
      rd_(MB + 32'h8);
      chk("timer_pending", last_rd, 32'h10);
      chk("timer_int", {26'd0, int_o}, 32'h10);
      wr_(MB + 32'h8, 32'h10);
      chk("timer_int_held", {26'd0, int_o}, 32'h10);
      idle();
      chk("timer_int_fall", {26'd0, int_o}, 32'd0);

      // external edge, single-cycle pulse
      wr_(MB + 32'hC, 32'h04);
      idle(4'h4); idle(); idle();
      chk("ext_int_not_yet", {26'd0, int_o}, 32'd0);
      rd_(MB + 32'h8);
      chk("ext_pending", last_rd, 32'h04);
      chk("ext_int", {26'd0, int_o}, 32'h04);
      wr_(MB + 32'h8, 32'h04);
      idle(); idle();
      // held high: one edge only
      idle(4'h4); idle(4'h4); idle(4'h4);
      wr_(MB + 32'h8, 32'h04, 4'hF, 4'h4);
      for (int i = 0; i < 4; i++) idle(4'h4);
      rd_(MB + 32'h8, 4'h4);
      chk("ext_no_retrigger", last_rd, 32'd0);

      // set wins over W1C
      idle(); idle(); idle();
      idle(4'h4); idle(4'h4);
      wr_(MB + 32'h8, 32'h04, 4'hF, 4'h4);
      rd_(MB + 32'h8, 4'h4);
      chk("set_wins", last_rd, 32'h04);
      wr_(MB + 32'h10, 32'h12345678, 4'hF, 4'h4);
      wr_(MB + 32'h10, 32'hFFFFFFFF, 4'b0011, 4'h4);
      rd_(MB + 32'h10, 4'h4);
      chk("scratch_partial_ignored", last_rd, 32'h12345678);
      wr_(MB + 32'hC, 32'h1F);
      idle(); idle();
      chk("int_before_reset", {26'd0, int_o}, 32'h04);

      // reset in the middle of a RAM write
      ce = 1; we = 1; sel = 4'hF; addr = 32'h40; wdata = 32'd0;
      #2 rst = 0;
      #1 chk("async_int_clear", {26'd0, int_o}, 32'd0);
      we = 0; #1;
      chk("reset_read_zero", rdata, 32'd0);
      we = 1;
      @(posedge clk);
      m_reset();
      @(negedge clk);
      ce = 0; rst = 1;
      rd_(MB + 32'h0);  chk("rst_count", last_rd, 32'd0);
      rd_(MB + 32'h4);  chk("rst_compare", last_rd, 32'd0);
      rd_(MB + 32'h8);  chk("rst_pending", last_rd, 32'd0);
      rd_(MB + 32'hC);  chk("rst_enable", last_rd, 32'd0);
      rd_(MB + 32'h10); chk("rst_scratch", last_rd, 32'd0);
      rd_(32'h40);      chk("rst_ram_kept", last_rd, 32'hDEADAAEF);

      // randomized traffic
      for (int n = 0; n < 500; n++) begin
         rs = $urandom_range(0, 1) ? 4'hF : 4'($urandom);
         rd = $urandom_range(0, 1) ? 32'($urandom) : 32'($urandom_range(0, 24));
         ra = $urandom_range(0, 1) ? {20'($urandom_range(0, 3)), 6'd0, 4'($urandom), 2'($urandom)}
                                   : {MB[31:12], 7'd0, 3'($urandom), 2'($urandom)};
         step($urandom_range(0, 3) != 0, 1'($urandom), rs, ra, rd, 4'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
